// File: rtl/aurora_64b66b_qpll_seq_ctrl.sv
// Reset/lock sequencer for the transceiver common PLLs of up to four quads.
// Every quad gets the same reset and power-down. Lock is synchronised and filtered.
// A lock timeout triggers a retry, a lock loss triggers a re-sequence, and repeated
// failures end in a sticky FAULT state that only a low enable clears.
module aurora_64b66b_qpll_seq_ctrl #(
    parameter int unsigned NUM_QUADS    = 2,
    parameter int unsigned RESET_CYCLES = 32,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned LOCK_FILTER  = 256,
    parameter int unsigned MAX_RETRY    = 7
) (
    input  logic                 init_clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_QUADS-1:0] qpll_lock_in,
    input  logic [NUM_QUADS-1:0] qpll_refclklost_in,
    output logic [NUM_QUADS-1:0] qpll_reset_out,
    output logic [NUM_QUADS-1:0] qpll_pd_out,
    output logic [NUM_QUADS-1:0] quad_locked,
    output logic                 all_locked,
    output logic                 fault,
    output logic [3:0]           retry_count,
    output logic [7:0]           loss_count,
    output logic [2:0]           state_out
);

    localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned TMR_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int unsigned FLT_W = (LOCK_FILTER > 1)  ? $clog2(LOCK_FILTER)  : 1;

    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RESET_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(LOCK_FILTER - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_REFCLK = 3'd1,
        ST_RESET       = 3'd2,
        ST_WAIT_LOCK   = 3'd3,
        ST_FILTER      = 3'd4,
        ST_LOCKED      = 3'd5,
        ST_FAULT       = 3'd6
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_QUADS-1:0] lock_meta_q, lock_sync_q;
    logic [NUM_QUADS-1:0] lost_meta_q, lost_sync_q;
    logic [NUM_QUADS-1:0] quad_locked_q;
    logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
    logic [TMR_W-1:0]     timer_q, timer_d, timer_inc_c;
    logic [FLT_W-1:0]     filt_cnt_q, filt_cnt_d, filt_inc_c;
    logic [3:0]           retry_q, retry_d;
    logic [7:0]           loss_q, loss_d;
    logic [NUM_QUADS-1:0] qpll_reset_q, qpll_pd_q;
    logic                 all_locked_q, fault_q;
    logic                 all_lock_c, any_lost_c, fail_c;
    logic                 rst_on_c, pd_on_c;

    // Two-flop synchronisers for the asynchronous PLL status, plus the per-quad lock copy
    always_ff @(posedge init_clk) begin
        if (reset) begin
            lock_meta_q   <= '0;
            lock_sync_q   <= '0;
            lost_meta_q   <= '0;
            lost_sync_q   <= '0;
            quad_locked_q <= '0;
        end else begin
            lock_meta_q   <= qpll_lock_in;
            lock_sync_q   <= lock_meta_q;
            lost_meta_q   <= qpll_refclklost_in;
            lost_sync_q   <= lost_meta_q;
            quad_locked_q <= lock_sync_q;
        end
    end

    assign all_lock_c  = &lock_sync_q;
    assign any_lost_c  = |lost_sync_q;
    assign timer_inc_c = (timer_q == TMR_LAST) ? timer_q : timer_q + TMR_W'(1);
    assign filt_inc_c  = (filt_cnt_q == FLT_LAST) ? filt_cnt_q : filt_cnt_q + FLT_W'(1);

    // Next-state, counter and retry/loss bookkeeping
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = '0;
        timer_d    = '0;
        filt_cnt_d = '0;
        retry_d    = retry_q;
        loss_d     = loss_q;
        fail_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_WAIT_REFCLK;
            end
            ST_WAIT_REFCLK: begin
                if (!any_lost_c) state_d = ST_RESET;
            end
            ST_RESET: begin
                if (rst_cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
                else                       rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
            ST_WAIT_LOCK: begin
                timer_d = timer_inc_c;
                if (any_lost_c)              state_d = ST_WAIT_REFCLK;
                else if (all_lock_c)         state_d = ST_FILTER;
                else if (timer_q == TMR_LAST) fail_c = 1'b1;
            end
            ST_FILTER: begin
                // attempt timer keeps running across filter restarts
                timer_d    = timer_inc_c;
                filt_cnt_d = filt_inc_c;
                if (any_lost_c) begin
                    state_d = ST_WAIT_REFCLK;
                end else if (!all_lock_c) begin
                    state_d = ST_WAIT_LOCK;
                end else if (filt_cnt_q == FLT_LAST) begin
                    state_d = ST_LOCKED;
                    retry_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    fail_c = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (any_lost_c || !all_lock_c) begin
                    loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                    state_d = any_lost_c ? ST_WAIT_REFCLK : ST_RESET;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fail_c) begin
            retry_d = retry_q + 4'd1;
            state_d = (retry_d == RETRY_MAX) ? ST_FAULT : ST_RESET;
        end

        // low enable overrides everything and suppresses loss counting
        if (!enable) begin
            state_d = ST_IDLE;
            loss_d  = loss_q;
        end

        if (state_d == ST_IDLE) retry_d = '0;
    end

    // Output levels decoded from the next state so they register together with it
    always_comb begin
        rst_on_c = (state_d == ST_IDLE) || (state_d == ST_WAIT_REFCLK) ||
                   (state_d == ST_RESET) || (state_d == ST_FAULT);
        pd_on_c  = (state_d == ST_IDLE) || (state_d == ST_FAULT);
    end

    // State, counters and registered outputs
    always_ff @(posedge init_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rst_cnt_q    <= '0;
            timer_q      <= '0;
            filt_cnt_q   <= '0;
            retry_q      <= '0;
            loss_q       <= '0;
            qpll_reset_q <= '1;
            qpll_pd_q    <= '1;
            all_locked_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            timer_q      <= timer_d;
            filt_cnt_q   <= filt_cnt_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            qpll_reset_q <= {NUM_QUADS{rst_on_c}};
            qpll_pd_q    <= {NUM_QUADS{pd_on_c}};
            all_locked_q <= (state_d == ST_LOCKED);
            fault_q      <= (state_d == ST_FAULT);
        end
    end

    assign qpll_reset_out = qpll_reset_q;
    assign qpll_pd_out    = qpll_pd_q;
    assign quad_locked    = quad_locked_q;
    assign all_locked     = all_locked_q;
    assign fault          = fault_q;
    assign retry_count    = retry_q;
    assign loss_count     = loss_q;
    assign state_out      = state_q;

endmodule

// File: tb/tb_aurora_64b66b_qpll_seq_ctrl.sv
// Bench for the QPLL sequencer: a cycle-exact vector table checked through an
// expectation queue, then hand-written timeout, glitch, lock-loss and refclk-loss sequences.
module tb_aurora_64b66b_qpll_seq_ctrl;

    localparam int unsigned NQ = 2;
    localparam int unsigned RC = 4;
    localparam int unsigned LT = 20;
    localparam int unsigned LF = 8;
    localparam int unsigned MR = 3;

    localparam logic [2:0] S_IDLE = 3'd0, S_WREF = 3'd1, S_RST = 3'd2, S_WLOCK = 3'd3,
                           S_FILT = 3'd4, S_LOCKED = 3'd5, S_FAULT = 3'd6;

    logic          clk = 1'b0;
    logic          reset, enable;
    logic [NQ-1:0] lock_in, lost_in;
    logic [NQ-1:0] qpll_reset_out, qpll_pd_out, quad_locked;
    logic          all_locked, fault;
    logic [3:0]    retry_count;
    logic [7:0]    loss_count;
    logic [2:0]    state_out;

    always #5 clk = ~clk;

    aurora_64b66b_qpll_seq_ctrl #(
        .NUM_QUADS(NQ), .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT),
        .LOCK_FILTER(LF), .MAX_RETRY(MR)
    ) dut (
        .init_clk          (clk),
        .reset             (reset),
        .enable            (enable),
        .qpll_lock_in      (lock_in),
        .qpll_refclklost_in(lost_in),
        .qpll_reset_out    (qpll_reset_out),
        .qpll_pd_out       (qpll_pd_out),
        .quad_locked       (quad_locked),
        .all_locked        (all_locked),
        .fault             (fault),
        .retry_count       (retry_count),
        .loss_count        (loss_count),
        .state_out         (state_out)
    );

    typedef struct {
        string      name;
        bit         rst;
        bit         en;
        logic [1:0] lock;
        logic [1:0] lost;
        int         hold;
        logic [2:0] st;
        logic [1:0] rsto;
        logic [1:0] pd;
        logic [1:0] ql;
        logic       al;
        logic       flt;
        logic [3:0] retry;
        logic [7:0] loss;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input string name, input bit rst, input bit en, input logic [1:0] lock,
                       input int hold, input logic [2:0] st, input logic [1:0] rsto,
                       input logic [1:0] pd, input logic [1:0] ql, input logic al,
                       input logic [7:0] loss);
        vec_t v;
        v.name = name; v.rst = rst; v.en = en; v.lock = lock; v.lost = 2'b00; v.hold = hold;
        v.st = st; v.rsto = rsto; v.pd = pd; v.ql = ql; v.al = al; v.flt = 1'b0;
        v.retry = 4'd0; v.loss = loss;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; lock_in = '0; lost_in = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int n = 0;
        while (state_out !== st && n < budget) begin
            tick();
            n++;
        end
        chk({name, ":reached"}, 32'(state_out), 32'(st));
    endtask

    // Counts consecutive cycles in st, tallying cycles where qpll_reset_out differs from rexp
    task automatic count_state(input logic [2:0] st, input int budget, input logic [1:0] rexp,
                               output int n, output int bad);
        n = 0; bad = 0;
        while (state_out === st && n < budget) begin
            if (qpll_reset_out !== rexp) bad++;
            n++;
            tick();
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad, ok, wl_fl, fcnt, k;
        bit saw_rst, saw_back;
        logic [2:0] prev;
        vec_t e;

        reset = 1'b1; enable = 1'b0; lock_in = '0; lost_in = '0;

        // ---------------- cycle-exact vector table ----------------
        //   name                rst en lock hold state     rsto   pd     ql     al loss
        add("reset",             1, 0, 2'b00, 3, S_IDLE,   2'b11, 2'b11, 2'b00, 0, 0);
        add("idle_to_wref",      0, 1, 2'b00, 1, S_WREF,   2'b11, 2'b00, 2'b00, 0, 0);
        add("wref_to_rst",       0, 1, 2'b00, 1, S_RST,    2'b11, 2'b00, 2'b00, 0, 0);
        add("rst_hold",          0, 1, 2'b00, 3, S_RST,    2'b11, 2'b00, 2'b00, 0, 0);
        add("rst_to_wlock",      0, 1, 2'b00, 1, S_WLOCK,  2'b00, 2'b00, 2'b00, 0, 0);
        add("wlock_sync",        0, 1, 2'b11, 2, S_WLOCK,  2'b00, 2'b00, 2'b00, 0, 0);
        add("wlock_to_filt",     0, 1, 2'b11, 1, S_FILT,   2'b00, 2'b00, 2'b11, 0, 0);
        add("filt_hold",         0, 1, 2'b11, 7, S_FILT,   2'b00, 2'b00, 2'b11, 0, 0);
        add("filt_to_locked",    0, 1, 2'b11, 1, S_LOCKED, 2'b00, 2'b00, 2'b11, 1, 0);
        add("drop_lock1",        0, 1, 2'b01, 1, S_LOCKED, 2'b00, 2'b00, 2'b11, 1, 0);
        add("drop_in_sync",      0, 1, 2'b11, 1, S_LOCKED, 2'b00, 2'b00, 2'b11, 1, 0);
        add("loss_to_rst",       0, 1, 2'b11, 1, S_RST,    2'b11, 2'b00, 2'b01, 0, 1);
        add("relock_rst",        0, 1, 2'b11, 3, S_RST,    2'b11, 2'b00, 2'b11, 0, 1);
        add("relock_wlock",      0, 1, 2'b11, 1, S_WLOCK,  2'b00, 2'b00, 2'b11, 0, 1);
        add("relock_filt",       0, 1, 2'b11, 1, S_FILT,   2'b00, 2'b00, 2'b11, 0, 1);
        add("relock_filt_hold",  0, 1, 2'b11, 7, S_FILT,   2'b00, 2'b00, 2'b11, 0, 1);
        add("relocked",          0, 1, 2'b11, 1, S_LOCKED, 2'b00, 2'b00, 2'b11, 1, 1);
        add("en_low_locked",     0, 0, 2'b11, 1, S_IDLE,   2'b11, 2'b11, 2'b11, 0, 1);
        add("en_high_again",     0, 1, 2'b11, 2, S_RST,    2'b11, 2'b00, 2'b11, 0, 1);
        add("en_low_in_rst",     0, 0, 2'b11, 1, S_IDLE,   2'b11, 2'b11, 2'b11, 0, 1);
        add("restart",           0, 1, 2'b11, 2, S_RST,    2'b11, 2'b00, 2'b11, 0, 1);
        add("restart_wlock",     0, 1, 2'b11, 4, S_WLOCK,  2'b00, 2'b00, 2'b11, 0, 1);
        add("restart_filt",      0, 1, 2'b11, 1, S_FILT,   2'b00, 2'b00, 2'b11, 0, 1);
        add("restart_filt_hold", 0, 1, 2'b11, 3, S_FILT,   2'b00, 2'b00, 2'b11, 0, 1);
        add("reset_in_filt",     1, 1, 2'b11, 1, S_IDLE,   2'b11, 2'b11, 2'b00, 0, 0);

        foreach (tbl[i]) begin
            reset   = tbl[i].rst;
            enable  = tbl[i].en;
            lock_in = tbl[i].lock;
            lost_in = tbl[i].lost;
            sb.push_back(tbl[i]);
            repeat (tbl[i].hold) tick();
            e = sb.pop_front();
            chk({e.name, ":state"},  32'(state_out),      32'(e.st));
            chk({e.name, ":rst"},    32'(qpll_reset_out), 32'(e.rsto));
            chk({e.name, ":pd"},     32'(qpll_pd_out),    32'(e.pd));
            chk({e.name, ":qlock"},  32'(quad_locked),    32'(e.ql));
            chk({e.name, ":alock"},  32'(all_locked),     32'(e.al));
            chk({e.name, ":fault"},  32'(fault),          32'(e.flt));
            chk({e.name, ":retry"},  32'(retry_count),    32'(e.retry));
            chk({e.name, ":loss"},   32'(loss_count),     32'(e.loss));
        end
        reset = 1'b0;

        // ---------------- lock timeout -> FAULT ----------------
        do_reset();
        enable = 1'b1; lock_in = 2'b01;
        for (int a = 1; a <= int'(MR); a++) begin
            wait_state(S_RST, 10, "to_reset");
            chk("retry_in_reset", 32'(retry_count), 32'(a - 1));
            count_state(S_RST, 50, 2'b11, n, bad);
            chk("reset_pulse_len", 32'(n), 32'(RC));
            chk("reset_pulse_level", 32'(bad), 32'd0);
            chk("after_reset_state", 32'(state_out), 32'(S_WLOCK));
            count_state(S_WLOCK, 50, 2'b00, n, bad);
            chk("wait_lock_len", 32'(n), 32'(LT));
            chk("wait_lock_rst_low", 32'(bad), 32'd0);
        end
        chk("fault_state", 32'(state_out), 32'(S_FAULT));
        chk("fault_flag", 32'(fault), 32'd1);
        chk("fault_retry", 32'(retry_count), 32'(MR));
        chk("fault_rst", 32'(qpll_reset_out), 32'(2'b11));
        chk("fault_pd", 32'(qpll_pd_out), 32'(2'b11));
        repeat (5) tick();
        chk("fault_sticky", 32'(state_out), 32'(S_FAULT));
        chk("fault_retry_frozen", 32'(retry_count), 32'(MR));
        enable = 1'b0;
        tick();
        chk("fault_exit_state", 32'(state_out), 32'(S_IDLE));
        chk("fault_exit_flag", 32'(fault), 32'd0);
        chk("fault_exit_retry", 32'(retry_count), 32'd0);

        // ---------------- filter glitch ----------------
        do_reset();
        enable = 1'b1; lock_in = 2'b11;
        wait_state(S_WLOCK, 20, "glitch_wlock");
        wl_fl = 0; fcnt = 0; k = 0; saw_rst = 1'b0; saw_back = 1'b0; prev = S_WLOCK;
        while (state_out !== S_LOCKED && k < 60) begin
            if (state_out === S_WLOCK || state_out === S_FILT) wl_fl++;
            if (state_out === S_RST) saw_rst = 1'b1;
            if (prev === S_FILT && state_out === S_WLOCK) saw_back = 1'b1;
            if (state_out === S_FILT && !saw_back) begin
                fcnt++;
                lock_in = (fcnt == 5) ? 2'b10 : 2'b11;
            end
            prev = state_out;
            tick();
            k++;
        end
        chk("glitch_locked", 32'(state_out), 32'(S_LOCKED));
        chk("glitch_no_reset", 32'(saw_rst), 32'd0);
        chk("glitch_back_to_wlock", 32'(saw_back), 32'd1);
        chk("glitch_window", 32'(wl_fl), 32'd17);
        chk("glitch_retry", 32'(retry_count), 32'd0);

        // ---------------- lock loss, repeated to saturation ----------------
        do_reset();
        enable = 1'b1; lock_in = 2'b11;
        wait_state(S_LOCKED, 60, "loss_first_lock");
        lock_in = 2'b01;
        tick();
        lock_in = 2'b11;
        chk("loss_al_t1", 32'(all_locked), 32'd1);
        tick();
        chk("loss_al_t2", 32'(all_locked), 32'd1);
        tick();
        chk("loss_al_t3", 32'(all_locked), 32'd0);
        chk("loss_state", 32'(state_out), 32'(S_RST));
        chk("loss_count_1", 32'(loss_count), 32'd1);
        count_state(S_RST, 50, 2'b11, n, bad);
        chk("loss_reset_len", 32'(n), 32'(RC));
        wait_state(S_LOCKED, 40, "loss_relock");
        ok = 0;
        for (int i = 2; i <= 300; i++) begin
            lock_in = 2'b01;
            tick();
            lock_in = 2'b11;
            k = 0;
            while (state_out === S_LOCKED && k < 10) begin tick(); k++; end
            k = 0;
            while (state_out !== S_LOCKED && k < 40) begin tick(); k++; end
            if (state_out === S_LOCKED) ok++;
        end
        chk("loss_relock_count", 32'(ok), 32'd299);
        chk("loss_count_sat", 32'(loss_count), 32'd255);

        // ---------------- refclk lost while locked ----------------
        lost_in = 2'b01; lock_in = 2'b10;
        repeat (3) tick();
        chk("lost_state", 32'(state_out), 32'(S_WREF));
        chk("lost_rst", 32'(qpll_reset_out), 32'(2'b11));
        chk("lost_pd", 32'(qpll_pd_out), 32'(2'b00));
        chk("lost_al", 32'(all_locked), 32'd0);
        chk("lost_loss_sat", 32'(loss_count), 32'd255);
        repeat (10) tick();
        chk("lost_no_timeout", 32'(state_out), 32'(S_WREF));
        chk("lost_retry", 32'(retry_count), 32'd0);
        lost_in = 2'b00; lock_in = 2'b11;
        wait_state(S_RST, 5, "lost_clear");
        count_state(S_RST, 50, 2'b11, n, bad);
        chk("lost_reset_len", 32'(n), 32'(RC));
        wait_state(S_LOCKED, 40, "lost_relock");
        chk("lost_relock_al", 32'(all_locked), 32'd1);
        chk("lost_relock_retry", 32'(retry_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
